ascii_fifo: RTL and testbench

ASCII_FIFO -- requirements
Module: ascii_fifo

---
 rtl/ascii_fifo.sv | 124 ++++++++++++
 tb/tb_ascii_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_fifo.sv
// rtl/ascii_fifo.sv - character FIFO with head-of-queue display and sticky overflow
//
// Purpose: stores WIDTH-bit characters in a DEPTH-entry circular buffer.
//   When the FIFO is empty, out_letter shows RESET_CHAR.
// Optional feature: `define ASCII_FIFO_ALPHA_FILTER_EN to accept only letters
//   A-Z / a-z, stored as uppercase. The filter is active only when WIDTH == 8.
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset of control state
//   clear      synchronous flush, takes priority over push/pop
//   in_letter  character to push
//   in_valid   push request
//   in_ready   FIFO can accept a push (!full)
//   out_letter head entry, or RESET_CHAR when empty
//   out_valid  head entry valid (!empty)
//   out_ready  consumer takes the head
//   count      number of stored entries
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky: push attempted while full
module ascii_fifo #(
   parameter int                 WIDTH      = 8,
   parameter int                 DEPTH      = 16,
   parameter logic [WIDTH-1:0]   RESET_CHAR = WIDTH'(8'h41)
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       clear,
   input  logic [WIDTH-1:0]           in_letter,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [WIDTH-1:0]           out_letter,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [0:DEPTH-1];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt_q;
   logic             ovf_q;

   logic             accept;
   logic [WIDTH-1:0] store_val;
   logic             push;
   logic             pop;
   logic             ovf_set;

`ifdef ASCII_FIFO_ALPHA_FILTER_EN
   generate
      if (WIDTH == 8) begin : g_filter
         logic is_upper;
         logic is_lower;
         assign is_upper  = (in_letter >= 8'h41) && (in_letter <= 8'h5A);
         assign is_lower  = (in_letter >= 8'h61) && (in_letter <= 8'h7A);
         assign accept    = is_upper || is_lower;
         // Lowercase and uppercase ASCII differ only in bit 5.
         assign store_val = is_lower ? (in_letter & ~8'h20) : in_letter;
      end else begin : g_no_filter
         assign accept    = 1'b1;
         assign store_val = in_letter;
      end
   endgenerate
`else
   assign accept    = 1'b1;
   assign store_val = in_letter;
`endif

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full      = (cnt_q == CW'(DEPTH));
   assign empty     = (cnt_q == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign count     = cnt_q;
   assign overflow  = ovf_q;

   // in_ready/out_valid gate these, so a full FIFO never bypasses and an
   // empty FIFO never passes a character straight through.
   assign push    = in_valid && in_ready && accept;
   assign pop     = out_valid && out_ready;
   // Filtered characters are dropped silently, even when full.
   assign ovf_set = in_valid && full && accept;

   assign out_letter = empty ? RESET_CHAR : mem[rd_ptr];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         if (push && !pop)
            cnt_q <= cnt_q + CW'(1);
         else if (pop && !push)
            cnt_q <= cnt_q - CW'(1);
         if (ovf_set) ovf_q <= 1'b1;
      end
   end

   // Storage carries no reset; only the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (push && !clear)
         mem[wr_ptr] <= store_val;
   end

endmodule

// File: tb/tb_ascii_fifo.sv
// tb/tb_ascii_fifo.sv - randomized self-checking bench for ascii_fifo against a queue model
module tb_ascii_fifo;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       clk_run = 1'b0;
   logic       resetn = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] in_letter = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_letter;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] count;
   logic       full;
   logic       empty;
   logic       overflow;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] mq [$];
   logic       m_ovf = 1'b0;

   ascii_fifo #(.WIDTH(8), .DEPTH(D), .RESET_CHAR(8'h41)) dut (
      .clk(clk), .resetn(resetn), .clear(clear),
      .in_letter(in_letter), .in_valid(in_valid), .in_ready(in_ready),
      .out_letter(out_letter), .out_valid(out_valid), .out_ready(out_ready),
      .count(count), .full(full), .empty(empty), .overflow(overflow)
   );

   initial forever begin
      #5;
      if (clk_run) clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic letter_ok(input logic [7:0] c);
`ifdef ASCII_FIFO_ALPHA_FILTER_EN
      return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [7:0] stored_form(input logic [7:0] c);
`ifdef ASCII_FIFO_ALPHA_FILTER_EN
      if (c >= "a" && c <= "z") return c - 8'd32;
`endif
      return c;
   endfunction

   function automatic logic [7:0] exp_head();
      return (mq.size() > 0) ? mq[0] : 8'h41;
   endfunction

   function automatic logic [7:0] rand_upper();
      return 8'h41 + 8'($urandom_range(0, 25));
   endfunction

   task automatic model_edge(input logic v, input logic [7:0] d, input logic r, input logic c);
      logic was_full;
      logic do_pop;
      if (c) begin
         mq.delete();
         m_ovf = 1'b0;
         return;
      end
      was_full = (mq.size() == D);
      do_pop   = r && (mq.size() > 0);
      if (v && letter_ok(d) && was_full) m_ovf = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (v && letter_ok(d) && !was_full) mq.push_back(stored_form(d));
   endtask

   // One clock: drive inputs, advance the model at the edge, settle on negedge.
   task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
      in_valid  = v;
      in_letter = d;
      out_ready = r;
      clear     = c;
      @(posedge clk);
      model_edge(v, d, r, c);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      clear     = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #20;
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
      vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
      vectors++; if (out_letter !== 8'h41) begin miscompares++; $display("FAIL reset_out_letter: got %h want 41", out_letter); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      vectors++; if (out_valid !== 1'b0 || full !== 1'b0) begin miscompares++; $display("FAIL reset_valid_full: got %b%b want 00", out_valid, full); end
      resetn = 1'b1;
      #2;
      clk_run = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fill_order();
      string s = "ENIG";
      for (int i = 0; i < 4; i++) step(1'b1, s[i], 1'b0, 1'b0);
      vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b want 1", full); end
      vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_count: got %0d want 4", count); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (out_letter !== s[i]) begin miscompares++; $display("FAIL order_%0d: got %h want %h", i, out_letter, s[i]); end
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got %b want 1", empty); end
      vectors++; if (out_letter !== 8'h41) begin miscompares++; $display("FAIL drain_out_letter: got %h want 41", out_letter); end
   endtask

   task automatic test_overflow();
      string s = "ENIG";
      for (int i = 0; i < 4; i++) step(1'b1, s[i], 1'b0, 1'b0);
      step(1'b1, "X", 1'b0, 1'b0);
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", overflow); end
      vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL ovf_count: got %0d want 4", count); end
      vectors++; if (out_letter !== "E") begin miscompares++; $display("FAIL ovf_head: got %h want 45", out_letter); end
      // Full with a pop in the same cycle: the push is still refused.
      step(1'b1, "Y", 1'b1, 1'b0);
      vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL ovf_nobypass_count: got %0d want 3", count); end
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      step(1'b1, "Z", 1'b1, 1'b1);
      vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL clear_count: got %0d want 0", count); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL clear_overflow: got %b want 0", overflow); end
   endtask

   task automatic test_wrap();
      step(1'b1, rand_upper(), 1'b0, 1'b0);
      step(1'b1, rand_upper(), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if (out_letter !== exp_head()) begin miscompares++; $display("FAIL wrap_head_%0d: got %h want %h", i, out_letter, exp_head()); end
         step(1'b1, rand_upper(), 1'b1, 1'b0);
         vectors++;
         if (count !== 3'd2) begin miscompares++; $display("FAIL wrap_count_%0d: got %0d want 2", i, count); end
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_midreset();
      for (int i = 0; i < 3; i++) step(1'b1, rand_upper(), 1'b0, 1'b0);
      vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL midreset_pre_count: got %0d want 3", count); end
      resetn = 1'b0;
      #1;
      mq.delete();
      m_ovf = 1'b0;
      vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL midreset_count: got %0d want 0", count); end
      vectors++; if (out_letter !== 8'h41 || empty !== 1'b1) begin miscompares++; $display("FAIL midreset_head: got %h/%b want 41/1", out_letter, empty); end
      #1;
      resetn = 1'b1;
      step(1'b1, "Q", 1'b1, 1'b0);
      vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL push_empty_count: got %0d want 1", count); end
      vectors++; if (out_letter !== "Q") begin miscompares++; $display("FAIL push_empty_head: got %h want 51", out_letter); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic [7:0] d;
         d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : rand_upper();
         if ($urandom_range(0, 1) == 1) d = d | 8'h20;
         step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
         vectors++;
         if (count !== 3'(mq.size())) begin miscompares++; $display("FAIL rand_count_%0d: got %0d want %0d", i, count, mq.size()); end
         vectors++;
         if (out_letter !== exp_head()) begin miscompares++; $display("FAIL rand_head_%0d: got %h want %h", i, out_letter, exp_head()); end
         vectors++;
         if ({full, empty, in_ready, out_valid} !== {mq.size() == D, mq.size() == 0, mq.size() != D, mq.size() != 0}) begin
            miscompares++;
            $display("FAIL rand_flags_%0d: got %b%b%b%b for size %0d", i, full, empty, in_ready, out_valid, mq.size());
         end
         vectors++;
         if (overflow !== m_ovf) begin miscompares++; $display("FAIL rand_overflow_%0d: got %b want %b", i, overflow, m_ovf); end
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

`ifdef ASCII_FIFO_ALPHA_FILTER_EN
   task automatic test_filter();
      step(1'b1, "b", 1'b0, 1'b0);
      step(1'b1, "3", 1'b0, 1'b0);
      step(1'b1, "Z", 1'b0, 1'b0);
      vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL filter_count: got %0d want 2", count); end
      vectors++; if (out_letter !== "B") begin miscompares++; $display("FAIL filter_first: got %h want 42", out_letter); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++; if (out_letter !== "Z") begin miscompares++; $display("FAIL filter_second: got %h want 5a", out_letter); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL filter_overflow: got %b want 0", overflow); end
      step(1'b0, 8'h00, 1'b0, 1'b1);
   endtask
`endif

   initial begin
      test_reset();
      test_fill_order();
      test_overflow();
      test_wrap();
      test_midreset();
`ifdef ASCII_FIFO_ALPHA_FILTER_EN
      test_filter();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
